// File: rtl/parking_gate_controller.sv
// Entry/exit barrier front end: sensor sync + debounce and one FSM per lane.
// Optional lane timeout in OPEN is built only when GATE_TIMEOUT_EN is defined.
module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLOSE_HOLD      = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic entry_approach,
    input  logic entry_pass,
    input  logic exit_approach,
    input  logic exit_pass,
    input  logic full_signal,
    output logic entry_gate_up,
    output logic exit_gate_up,
    output logic car_arrival,
    output logic car_departure,
    output logic entry_denied,
    output logic timeout_flag
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(CLOSE_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_PASS,
        S_HOLD
    } lane_state_e;

    // Sensor bit order: [0] entry approach, [1] entry pass,
    // [2] exit approach, [3] exit pass.
    logic [3:0]    raw;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    db_q;
    logic [3:0]    db_d;
    logic [DW-1:0] dcnt_q [4];
    logic [DW-1:0] dcnt_d [4];

    // Lane index: 0 = entry, 1 = exit.
    logic [1:0]    appr;
    logic [1:0]    pass;
    logic [1:0]    allow;
    logic [1:0]    expire;
    lane_state_e   state_q [2];
    lane_state_e   state_d [2];
    logic [HW-1:0] hcnt_q  [2];
    logic [HW-1:0] hcnt_d  [2];

    logic [1:0]    gate_q;
    logic [1:0]    gate_d;
    logic [1:0]    pulse_q;
    logic [1:0]    pulse_d;
    logic          denied_q;
    logic          denied_d;

    assign raw = {exit_pass, exit_approach, entry_pass, entry_approach};

    // Synchroniser chain, debounced levels and stability counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
        end
    end

    // Count consecutive mismatches; flip the level on the last one.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lanes act on the new debounced level in the edge it changes.
    assign appr  = {db_d[2], db_d[0]};
    assign pass  = {db_d[3], db_d[1]};
    assign allow = {1'b1, ~full_signal};

    // Lane state and hold-counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < 2; l++) begin
                state_q[l] <= S_IDLE;
                hcnt_q[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                state_q[l] <= state_d[l];
                hcnt_q[l]  <= hcnt_d[l];
            end
        end
    end

    // Lane next-state; a beam seen in IDLE or HOLD has no effect.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            state_d[l] = state_q[l];
            case (state_q[l])
                S_IDLE: begin
                    if (appr[l] && allow[l]) state_d[l] = S_OPEN;
                end
                S_OPEN: begin
                    if (pass[l])        state_d[l] = S_PASS;
                    else if (expire[l]) state_d[l] = S_HOLD;
                end
                S_PASS: begin
                    if (!pass[l]) state_d[l] = S_HOLD;
                end
                S_HOLD: begin
                    if (hcnt_q[l] == HW'(CLOSE_HOLD - 1)) state_d[l] = S_IDLE;
                end
                default: state_d[l] = S_IDLE;
            endcase
            hcnt_d[l] = '0;
            if (state_q[l] == S_HOLD && state_d[l] == S_HOLD) begin
                hcnt_d[l] = hcnt_q[l] + 1'b1;
            end
        end
    end

    // Output decode from the next state so outputs register with it.
    always_comb begin
        gate_d  = '0;
        pulse_d = '0;
        for (int l = 0; l < 2; l++) begin
            gate_d[l]  = (state_d[l] == S_OPEN) || (state_d[l] == S_PASS);
            pulse_d[l] = (state_q[l] == S_PASS) && (state_d[l] == S_HOLD);
        end
        denied_d = (state_d[0] == S_IDLE) && appr[0] && full_signal;
    end

    // Registered outputs; reset drops barriers and kills any pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gate_q   <= '0;
            pulse_q  <= '0;
            denied_q <= 1'b0;
        end else begin
            gate_q   <= gate_d;
            pulse_q  <= pulse_d;
            denied_q <= denied_d;
        end
    end

    assign entry_gate_up = gate_q[0];
    assign exit_gate_up  = gate_q[1];
    assign car_arrival   = pulse_q[0];
    assign car_departure = pulse_q[1];
    assign entry_denied  = denied_q;

`ifdef GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt_q [2];
    logic [TW-1:0] tcnt_d [2];
    logic          tmo_q;
    logic          tmo_d;

    // Lane gives up on the car after TIMEOUT_CYCLES in OPEN.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            expire[l] = (tcnt_q[l] == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    // OPEN-time counters, cleared whenever the lane leaves OPEN.
    always_comb begin
        tmo_d = 1'b0;
        for (int l = 0; l < 2; l++) begin
            tcnt_d[l] = '0;
            if (state_q[l] == S_OPEN && state_d[l] == S_OPEN) begin
                tcnt_d[l] = tcnt_q[l] + 1'b1;
            end
            if (state_q[l] == S_OPEN && state_d[l] == S_HOLD) begin
                tmo_d = 1'b1;
            end
        end
    end

    // Timeout counters and flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < 2; l++) tcnt_q[l] <= '0;
            tmo_q <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) tcnt_q[l] <= tcnt_d[l];
            tmo_q <= tmo_d;
        end
    end

    assign timeout_flag = tmo_q;
`else
    // OPEN waits indefinitely; the timeout length has no effect here.
    assign expire       = '0;
    assign timeout_flag = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller (DEBOUNCE 4, HOLD 8, TIMEOUT 16).
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_parking_gate_controller;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic entry_approach = 1'b0;
    logic entry_pass = 1'b0;
    logic exit_approach = 1'b0;
    logic exit_pass = 1'b0;
    logic full_signal = 1'b0;
    logic entry_gate_up;
    logic exit_gate_up;
    logic car_arrival;
    logic car_departure;
    logic entry_denied;
    logic timeout_flag;

    int n_run = 0;
    int n_fail = 0;
    int arr_n = 0;
    int dep_n = 0;
    int a0;
    int d0;

    always #5 clock = ~clock;

    parking_gate_controller #(
        .DEBOUNCE_CYCLES(4),
        .CLOSE_HOLD     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .entry_approach(entry_approach),
        .entry_pass    (entry_pass),
        .exit_approach (exit_approach),
        .exit_pass     (exit_pass),
        .full_signal   (full_signal),
        .entry_gate_up (entry_gate_up),
        .exit_gate_up  (exit_gate_up),
        .car_arrival   (car_arrival),
        .car_departure (car_departure),
        .entry_denied  (entry_denied),
        .timeout_flag  (timeout_flag)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (car_arrival)   arr_n++;
        if (car_departure) dep_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rst();
        reset_n = 1'b0;
        entry_approach = 1'b0;
        entry_pass = 1'b0;
        exit_approach = 1'b0;
        exit_pass = 1'b0;
        full_signal = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        // 1. reset with all sensors high
        entry_approach = 1'b1;
        entry_pass = 1'b1;
        exit_approach = 1'b1;
        exit_pass = 1'b1;
        tick(3);
        chk("rst_outs", {entry_gate_up, exit_gate_up, car_arrival,
                         car_departure, entry_denied, timeout_flag}, 0);
        reset_n = 1'b1;
        tick(5);
        chk("rst_gate_t5", entry_gate_up, 0);
        tick(1);
        chk("rst_gate_t6", entry_gate_up, 1);
        chk("rst_xgate_t6", exit_gate_up, 1);
        rst();

        // 2. normal entry
        a0 = arr_n;
        entry_approach = 1'b1;
        tick(5);
        chk("ent_gate_t5", entry_gate_up, 0);
        tick(1);
        chk("ent_gate_t6", entry_gate_up, 1);
        tick(2);
        entry_pass = 1'b1;
        tick(10);
        entry_pass = 1'b0;
        tick(2);
        entry_approach = 1'b0;
        tick(3);
        chk("ent_arr_f5", car_arrival, 0);
        chk("ent_gate_f5", entry_gate_up, 1);
        tick(1);
        chk("ent_arr_f6", car_arrival, 1);
        chk("ent_gate_f6", entry_gate_up, 0);
        tick(1);
        chk("ent_arr_f7", car_arrival, 0);
        tick(17);
        chk("ent_gate_idle", entry_gate_up, 0);
        chk("ent_arr_count", arr_n - a0, 1);

        // 2b. re-arm with car still on the approach loop
        rst();
        entry_approach = 1'b1;
        tick(6);
        chk("rearm_open", entry_gate_up, 1);
        entry_pass = 1'b1;
        tick(6);
        entry_pass = 1'b0;
        tick(6);
        chk("rearm_arr", car_arrival, 1);
        chk("rearm_down", entry_gate_up, 0);
        tick(8);
        chk("rearm_hold8", entry_gate_up, 0);
        tick(1);
        chk("rearm_reopen", entry_gate_up, 1);

        // 3. lot full
        rst();
        a0 = arr_n;
        full_signal = 1'b1;
        entry_approach = 1'b1;
        tick(8);
        chk("full_denied", entry_denied, 1);
        chk("full_gate", entry_gate_up, 0);
        tick(10);
        chk("full_gate_late", entry_gate_up, 0);
        chk("full_no_arr", arr_n - a0, 0);
        full_signal = 1'b0;
        tick(1);
        chk("full_drop_gate", entry_gate_up, 1);
        chk("full_drop_deny", entry_denied, 0);

        // 4. glitches
        rst();
        a0 = arr_n;
        d0 = dep_n;
        entry_approach = 1'b1;
        exit_pass = 1'b1;
        tick(2);
        entry_approach = 1'b0;
        tick(1);
        exit_pass = 1'b0;
        tick(20);
        chk("glitch_gates", {entry_gate_up, exit_gate_up}, 0);
        chk("glitch_pulses", (arr_n - a0) + (dep_n - d0), 0);
        entry_approach = 1'b1;
        tick(6);
        chk("glitch_then_real", entry_gate_up, 1);

        // 5. simultaneous lanes, then reset mid-PASSING
        rst();
        entry_approach = 1'b1;
        exit_approach = 1'b1;
        tick(6);
        chk("sim_gates", {entry_gate_up, exit_gate_up}, 2'b11);
        entry_pass = 1'b1;
        exit_pass = 1'b1;
        tick(10);
        entry_pass = 1'b0;
        exit_pass = 1'b0;
        tick(6);
        chk("sim_pulses", {car_arrival, car_departure}, 2'b11);
        entry_approach = 1'b0;
        exit_approach = 1'b0;
        tick(12);
        entry_approach = 1'b1;
        exit_approach = 1'b1;
        tick(6);
        entry_pass = 1'b1;
        exit_pass = 1'b1;
        tick(8);
        chk("sim2_gates", {entry_gate_up, exit_gate_up}, 2'b11);
        a0 = arr_n;
        d0 = dep_n;
        reset_n = 1'b0;
        #1;
        chk("sim2_rst_gates", {entry_gate_up, exit_gate_up}, 0);
        chk("sim2_rst_pulse", {car_arrival, car_departure}, 0);
        entry_approach = 1'b0;
        exit_approach = 1'b0;
        entry_pass = 1'b0;
        exit_pass = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(20);
        chk("sim2_no_pulse", (arr_n - a0) + (dep_n - d0), 0);
        chk("sim2_gates_low", {entry_gate_up, exit_gate_up}, 0);

        // 6. exit lane with no car passing
        rst();
        d0 = dep_n;
        exit_approach = 1'b1;
        tick(6);
        chk("tmo_open", exit_gate_up, 1);
`ifdef GATE_TIMEOUT_EN
        tick(15);
        chk("tmo_flag_t15", timeout_flag, 0);
        chk("tmo_gate_t15", exit_gate_up, 1);
        tick(1);
        chk("tmo_flag_t16", timeout_flag, 1);
        chk("tmo_gate_t16", exit_gate_up, 0);
        tick(1);
        chk("tmo_flag_t17", timeout_flag, 0);
        chk("tmo_no_dep", dep_n - d0, 0);
`else
        tick(30);
        chk("tmo_gate_stays", exit_gate_up, 1);
        chk("tmo_flag_zero", timeout_flag, 0);
        chk("tmo_no_dep", dep_n - d0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
